pb_channel_seq: RTL and testbench



---
 rtl/pb_pkg.sv | 16 +
 rtl/pb_channel_seq_if.sv | 54 +++++
 rtl/pb_edge_det.sv | 21 ++
 rtl/pb_channel_seq.sv | 173 +++++++++++++++++
 tb/tb_pb_channel_seq.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pb_pkg.sv
// Shared types and defaults for the per-channel playback sequencer.
package pb_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int HP_W_DEF   = 20;
   // Smallest half period the prefetch pipeline can sustain without gaps.
   localparam int HP_MIN     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      PLAY  = 2'd2,
      DONE  = 2'd3
   } pb_state_e;

endpackage

// File: rtl/pb_channel_seq_if.sv
// Control, RAM and debug signals of one playback channel.
//
// Signalling: there is no valid/ready handshake. write_addr, write_stop_addr,
// write_ram, write_hp and playback_en are level inputs whose rising edge is
// the event; the sequencer acts on an edge in the cycle it is seen. ram_we is
// a one-cycle write pulse. ram_rdata must hold mem[ram_addr] of the previous
// cycle (one-cycle synchronous read).
interface pb_channel_seq_if
   import pb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int HP_W   = HP_W_DEF
);
   logic              mode;
   logic              playback_en;
   logic              loop_pb;
   logic              din;
   logic              write_addr;
   logic              write_stop_addr;
   logic              write_ram;
   logic              write_hp;
   logic [ADDR_W-1:0] addr_in;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic              ram_wdata;
   logic              ram_rdata;

   logic              pb_out;
   logic              busy;
   logic              done;

   pb_state_e         state_dbg;
   logic [ADDR_W-1:0] wr_ptr_dbg;
   logic [ADDR_W-1:0] stop_addr_dbg;
   logic [HP_W-1:0]   hp_dbg;

   // The sequencer masters the RAM port and drives the playback outputs.
   modport master (
      input  mode, playback_en, loop_pb, din, write_addr, write_stop_addr,
             write_ram, write_hp, addr_in, ram_rdata,
      output ram_addr, ram_we, ram_wdata, pb_out, busy, done,
             state_dbg, wr_ptr_dbg, stop_addr_dbg, hp_dbg
   );

   // GPIO bridge plus RAM side.
   modport slave (
      output mode, playback_en, loop_pb, din, write_addr, write_stop_addr,
             write_ram, write_hp, addr_in, ram_rdata,
      input  ram_addr, ram_we, ram_wdata, pb_out, busy, done,
             state_dbg, wr_ptr_dbg, stop_addr_dbg, hp_dbg
   );

endinterface

// File: rtl/pb_edge_det.sv
// Rising-edge detector for a bundle of level inputs.
module pb_edge_det #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] sig_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] prev_q;

   // Remember last cycle's levels.
   always_ff @(posedge clk) begin
      if (rst) prev_q <= '0;
      else     prev_q <= sig_i;
   end

   assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/pb_channel_seq.sv
// Per-channel playback sequencer: config/RAM load in IDLE with mode=1,
// pattern playback from address 0 to stop_addr with mode=0.
module pb_channel_seq
   import pb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int HP_W       = HP_W_DEF,
   parameter int HP_DEFAULT = 2
) (
   input logic              clk,
   input logic              rst,
   pb_channel_seq_if.master bus
);

   logic [4:0]        strobe_raw, strobe_rise;
   logic              pb_rise, wa_rise, ws_rise, wr_rise, wh_rise;

   pb_state_e         state_q;
   logic              fetch_wait_q, wrap_q;
   logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q, stop_addr_q, ram_addr_q;
   logic [HP_W-1:0]   hp_cnt_q, half_period_q;
   logic              ram_we_q, ram_wdata_q, pb_out_q, busy_q, done_q;

   logic              cfg_en, abort, at_last_cnt, pf_wrap_d;
   logic [ADDR_W-1:0] wr_addr_d, pf_base_d, pf_addr_d;
   logic [HP_W-1:0]   hp_in, hp_clamp_d, hp_cnt_d, hp_m1, hp_m2;

   assign strobe_raw = {bus.write_hp, bus.write_ram, bus.write_stop_addr,
                        bus.write_addr, bus.playback_en};

   pb_edge_det #(.W(5)) u_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (strobe_raw),
      .rise_o (strobe_rise)
   );

   assign {wh_rise, wr_rise, ws_rise, wa_rise, pb_rise} = strobe_rise;

   assign cfg_en = bus.mode && (state_q == IDLE);
   assign abort  = !bus.playback_en || bus.mode;

   // A write_addr edge in the same cycle as a write_ram edge redirects the write.
   assign wr_addr_d  = wa_rise ? bus.addr_in : wr_ptr_q;
   assign hp_in      = bus.addr_in[HP_W-1:0];
   assign hp_clamp_d = (hp_in < HP_W'(HP_MIN)) ? HP_W'(HP_MIN) : hp_in;

   assign hp_m1       = half_period_q - HP_W'(1);
   assign hp_m2       = half_period_q - HP_W'(2);
   assign at_last_cnt = (hp_cnt_q == hp_m1);
   assign hp_cnt_d    = hp_cnt_q + HP_W'(1);

   // Prefetch address for the bit after the one being held. At a bit boundary
   // the new current address is the one already sitting on ram_addr. The wrap
   // decision is latched with the prefetch so the boundary stays consistent
   // with the data that was actually fetched.
   assign pf_base_d = (state_q == PLAY && at_last_cnt) ? ram_addr_q : rd_ptr_q;
   assign pf_wrap_d = bus.loop_pb && (pf_base_d == stop_addr_q);
   assign pf_addr_d = pf_wrap_d ? '0 : pf_base_d + ADDR_W'(1);

   // Config registers, RAM write pulse and playback FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         fetch_wait_q  <= 1'b0;
         wrap_q        <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         stop_addr_q   <= '0;
         ram_addr_q    <= '0;
         hp_cnt_q      <= '0;
         half_period_q <= HP_W'(HP_DEFAULT);
         ram_we_q      <= 1'b0;
         ram_wdata_q   <= 1'b0;
         pb_out_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         ram_we_q <= 1'b0;
         if (cfg_en) begin
            if (wa_rise) wr_ptr_q      <= bus.addr_in;
            if (ws_rise) stop_addr_q   <= bus.addr_in;
            if (wh_rise) half_period_q <= hp_clamp_d;
            if (wr_rise) begin
               ram_we_q    <= 1'b1;
               ram_addr_q  <= wr_addr_d;
               ram_wdata_q <= bus.din;
               wr_ptr_q    <= wr_addr_d + ADDR_W'(1);
            end
         end
         case (state_q)
            IDLE: begin
               if (pb_rise && !bus.mode) begin
                  state_q      <= FETCH;
                  fetch_wait_q <= 1'b0;
                  rd_ptr_q     <= '0;
                  ram_addr_q   <= '0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pb_out_q     <= 1'b0;
               end
            end
            FETCH: begin
               if (abort) begin
                  state_q  <= IDLE;
                  pb_out_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b0;
               end else if (!fetch_wait_q) begin
                  // Address 0 is on the RAM port this cycle; data arrives next.
                  fetch_wait_q <= 1'b1;
               end else begin
                  pb_out_q <= bus.ram_rdata;
                  hp_cnt_q <= '0;
                  state_q  <= PLAY;
                  if (hp_m2 == '0) begin
                     ram_addr_q <= pf_addr_d;
                     wrap_q     <= pf_wrap_d;
                  end
               end
            end
            PLAY: begin
               if (abort) begin
                  state_q  <= IDLE;
                  pb_out_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b0;
               end else if (at_last_cnt) begin
                  if ((rd_ptr_q == stop_addr_q) && !wrap_q) begin
                     state_q  <= DONE;
                     pb_out_q <= 1'b0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end else begin
                     pb_out_q <= bus.ram_rdata;
                     rd_ptr_q <= ram_addr_q;
                     hp_cnt_q <= '0;
                     if (hp_m2 == '0) begin
                        ram_addr_q <= pf_addr_d;
                        wrap_q     <= pf_wrap_d;
                     end
                  end
               end else begin
                  hp_cnt_q <= hp_cnt_d;
                  if (hp_cnt_d == hp_m2) begin
                     ram_addr_q <= pf_addr_d;
                     wrap_q     <= pf_wrap_d;
                  end
               end
            end
            DONE: begin
               if (!bus.playback_en) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ram_addr      = ram_addr_q;
   assign bus.ram_we        = ram_we_q;
   assign bus.ram_wdata     = ram_wdata_q;
   assign bus.pb_out        = pb_out_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.state_dbg     = state_q;
   assign bus.wr_ptr_dbg    = wr_ptr_q;
   assign bus.stop_addr_dbg = stop_addr_q;
   assign bus.hp_dbg        = half_period_q;

endmodule

// File: tb/tb_pb_channel_seq.sv
// Bench for pb_channel_seq: RAM model, directed config/playback sequences,
// scoreboard queues for RAM writes and played-back bits.
module tb_pb_channel_seq;
   import pb_pkg::*;

   localparam int AW = 20;
   localparam int HW = 20;

   logic clk;
   logic rst;

   pb_channel_seq_if #(.ADDR_W(AW), .HP_W(HW)) bus ();

   pb_channel_seq #(.ADDR_W(AW), .HP_W(HW), .HP_DEFAULT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int checks = 0;
   int errors = 0;

   logic [AW:0] exp_wr_q[$];
   logic        exp_pb_q[$];
   logic [AW:0] mon_wr_e;
   logic        mon_pb_e;
   logic        mem [0:255];

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port RAM, one-cycle read latency (low address bits suffice here)
   always @(posedge clk) begin
      if (bus.ram_we === 1'b1) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr[7:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: every RAM write pulse and every PLAY cycle pops an expectation
   always @(negedge clk) begin
      if (bus.ram_we === 1'b1) begin
         checks++;
         if (exp_wr_q.size() == 0) begin
            errors++;
            $display("FAIL ram_write: got addr 0x%0h data %0d expected no write",
                     bus.ram_addr, bus.ram_wdata);
         end else begin
            mon_wr_e = exp_wr_q.pop_front();
            if ({bus.ram_addr, bus.ram_wdata} !== mon_wr_e) begin
               errors++;
               $display("FAIL ram_write: got addr 0x%0h data %0d expected addr 0x%0h data %0d",
                        bus.ram_addr, bus.ram_wdata, mon_wr_e[AW:1], mon_wr_e[0]);
            end
         end
      end
      if (bus.state_dbg == PLAY) begin
         checks++;
         if (exp_pb_q.size() == 0) begin
            errors++;
            $display("FAIL pb_out_bit: got %0d expected no PLAY cycle", bus.pb_out);
         end else begin
            mon_pb_e = exp_pb_q.pop_front();
            if (bus.pb_out !== mon_pb_e) begin
               errors++;
               $display("FAIL pb_out_bit: got %0d expected %0d", bus.pb_out, mon_pb_e);
            end
         end
      end
   end

   // drivers
   task automatic pulse(input logic wa, input logic ws, input logic wr, input logic wh,
                        input logic [AW-1:0] val, input logic d);
      @(posedge clk); #1;
      bus.addr_in         = val;
      bus.din             = d;
      bus.write_addr      = wa;
      bus.write_stop_addr = ws;
      bus.write_ram       = wr;
      bus.write_hp        = wh;
      @(posedge clk); #1;
      bus.write_addr      = 1'b0;
      bus.write_stop_addr = 1'b0;
      bus.write_ram       = 1'b0;
      bus.write_hp        = 1'b0;
   endtask

   task automatic write_bit(input logic d, input logic [AW-1:0] exp_addr);
      exp_wr_q.push_back({exp_addr, d});
      pulse(1'b0, 1'b0, 1'b1, 1'b0, '0, d);
   endtask

   // bits[0] is played first; each bit is expected for hp PLAY cycles
   task automatic push_pattern(input logic [3:0] bits, input int nbits, input int hp);
      for (int i = 0; i < nbits; i++)
         for (int k = 0; k < hp; k++)
            exp_pb_q.push_back(bits[i]);
   endtask

   task automatic wait_state(input pb_state_e s, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.state_dbg != s && n < 50);
      chk(name, 32'(bus.state_dbg), 32'(s));
   endtask

   // raise playback_en, count negedges until DONE (n=1 is the raising cycle)
   task automatic run_play(input string name, input int exp_n, input int drop_loop_at);
      int n;
      n = 0;
      @(posedge clk); #1;
      bus.mode        = 1'b0;
      bus.playback_en = 1'b1;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (n == drop_loop_at) bus.loop_pb = 1'b0;
         if (n == 2) chk({name, "_fetch"}, 32'(bus.state_dbg), 32'(FETCH));
         if (n == 4) chk({name, "_first_bit_play"}, 32'(bus.state_dbg), 32'(PLAY));
         if (bus.state_dbg == DONE) break;
      end
      chk({name, "_cycles_to_done"}, n, exp_n);
      chk({name, "_done"}, bus.done, 1);
      chk({name, "_busy"}, bus.busy, 0);
      chk({name, "_pb_out"}, bus.pb_out, 0);
      @(posedge clk); #1;
      bus.playback_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({name, "_back_idle"}, 32'(bus.state_dbg), 32'(IDLE));
      chk({name, "_done_clr"}, bus.done, 0);
   endtask

   task automatic check_reset(input string p);
      chk({p, "_pb_out"},    bus.pb_out, 0);
      chk({p, "_ram_we"},    bus.ram_we, 0);
      chk({p, "_ram_wdata"}, bus.ram_wdata, 0);
      chk({p, "_ram_addr"},  bus.ram_addr, 0);
      chk({p, "_busy"},      bus.busy, 0);
      chk({p, "_done"},      bus.done, 0);
      chk({p, "_state"},     32'(bus.state_dbg), 32'(IDLE));
      chk({p, "_wr_ptr"},    bus.wr_ptr_dbg, 0);
      chk({p, "_stop"},      bus.stop_addr_dbg, 0);
      chk({p, "_hp"},        bus.hp_dbg, 2);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 1'b0;
      rst                 = 1'b1;
      bus.mode            = 1'b0;
      bus.playback_en     = 1'b0;
      bus.loop_pb         = 1'b0;
      bus.din             = 1'b0;
      bus.write_addr      = 1'b0;
      bus.write_stop_addr = 1'b0;
      bus.write_ram       = 1'b0;
      bus.write_hp        = 1'b0;
      bus.addr_in         = '0;

      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // load pattern 1,0,1,1 at 0..3, stop 3, half period 4
      bus.mode = 1'b1;
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0);
      write_bit(1'b1, 20'h0);
      write_bit(1'b0, 20'h1);
      write_bit(1'b1, 20'h2);
      write_bit(1'b1, 20'h3);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 20'h3, 1'b0);
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 20'h4, 1'b0);
      @(negedge clk);
      chk("load_wr_ptr", bus.wr_ptr_dbg, 4);
      chk("load_stop", bus.stop_addr_dbg, 3);
      chk("load_hp", bus.hp_dbg, 4);

      // play once: 16 PLAY cycles starting 3 cycles after the raise
      push_pattern(4'b1101, 4, 4);
      run_play("play_once", 20, 0);

      // loop two passes, loop_pb dropped during the second pass
      bus.loop_pb = 1'b1;
      push_pattern(4'b1101, 4, 4);
      push_pattern(4'b1101, 4, 4);
      run_play("loop", 36, 24);

      // abort in the 6th PLAY cycle, then restart from address 0
      exp_pb_q.push_back(1'b1); exp_pb_q.push_back(1'b1);
      exp_pb_q.push_back(1'b1); exp_pb_q.push_back(1'b1);
      exp_pb_q.push_back(1'b0); exp_pb_q.push_back(1'b0);
      @(posedge clk); #1;
      bus.playback_en = 1'b1;
      wait_state(PLAY, "abort_reach_play");
      repeat (5) @(posedge clk);
      #1 bus.playback_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_state", 32'(bus.state_dbg), 32'(IDLE));
      chk("abort_pb_out", bus.pb_out, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      push_pattern(4'b1101, 4, 4);
      run_play("restart", 20, 0);

      // half period 0 and 1 clamp to 2
      bus.mode = 1'b1;
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 20'h0, 1'b0);
      @(negedge clk);
      chk("hp_clamp0", bus.hp_dbg, 2);
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 20'h1, 1'b0);
      @(negedge clk);
      chk("hp_clamp1", bus.hp_dbg, 2);
      push_pattern(4'b1101, 4, 2);
      run_play("hp2", 12, 0);

      // write pointer wrap
      bus.mode = 1'b1;
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 20'hFFFFF, 1'b0);
      write_bit(1'b1, 20'hFFFFF);
      write_bit(1'b0, 20'h00000);
      @(negedge clk);
      chk("wrap_wr_ptr", bus.wr_ptr_dbg, 1);

      // simultaneous write_addr and write_ram
      exp_wr_q.push_back({20'h10, 1'b1});
      pulse(1'b1, 1'b0, 1'b1, 1'b0, 20'h10, 1'b1);
      @(negedge clk);
      chk("simul_wr_ptr", bus.wr_ptr_dbg, 20'h11);

      // config strobes during playback are ignored (memory now 0,0,1,1)
      push_pattern(4'b1100, 4, 2);
      fork
         run_play("cfg_ignored", 12, 0);
         begin
            repeat (3) @(posedge clk);
            pulse(1'b1, 1'b1, 1'b1, 1'b1, 20'h55, 1'b1);
         end
      join
      chk("ign_wr_ptr", bus.wr_ptr_dbg, 20'h11);
      chk("ign_stop", bus.stop_addr_dbg, 3);
      chk("ign_hp", bus.hp_dbg, 2);

      // stop address 0: one-bit pattern
      bus.mode = 1'b1;
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0);
      write_bit(1'b1, 20'h0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
      push_pattern(4'b0001, 1, 2);
      run_play("stop0", 6, 0);

      // reset in the 3rd PLAY cycle
      bus.mode = 1'b1;
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 20'h4, 1'b0);
      exp_pb_q.push_back(1'b1); exp_pb_q.push_back(1'b1); exp_pb_q.push_back(1'b1);
      @(posedge clk); #1;
      bus.mode        = 1'b0;
      bus.playback_en = 1'b1;
      wait_state(PLAY, "rst_reach_play");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset("midplay_reset");
      bus.playback_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      repeat (3) @(negedge clk);
      chk("wr_queue_empty", exp_wr_q.size(), 0);
      chk("pb_queue_empty", exp_pb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
